afifo_rd_ctrl: RTL

- Read-domain control for the async FIFO. Counterpart of the write-domain read-pointer synchronizer.
- Synchronizes the write Gray pointer into the read clock domain and maintains the binary and Gray read pointers.
- Generates the RAM read address, empty / almost-empty flags, fill count, read-acknowledge and underflow indications.
- Sits between the FIFO RAM read port and the user read interface. rptr_gray_o feeds the write-domain synchronizer.

---
 rtl/afifo_rd_ctrl_if.sv | 27 ++
 rtl/afifo_rd_ctrl.sv | 79 +++++++
 2 files changed

// File: rtl/afifo_rd_ctrl_if.sv
// Read-side bus of the async FIFO: write Gray pointer and read request in,
// read pointer, RAM address, flags and pulses out.
interface afifo_rd_ctrl_if #(
    parameter int PTR_WIDTH = 5
);
    logic [PTR_WIDTH:0]   wptr_gray_i;
    logic                 rd_en_i;
    logic [PTR_WIDTH:0]   rptr_gray_o;
    logic [PTR_WIDTH-1:0] raddr_o;
    logic                 rempty_o;
    logic                 ralmost_empty_o;
    logic [PTR_WIDTH:0]   rd_cnt_o;
    logic                 rd_ack_o;
    logic                 underflow_o;

    modport master (
        output wptr_gray_i, rd_en_i,
        input  rptr_gray_o, raddr_o, rempty_o, ralmost_empty_o,
               rd_cnt_o, rd_ack_o, underflow_o
    );

    modport slave (
        input  wptr_gray_i, rd_en_i,
        output rptr_gray_o, raddr_o, rempty_o, ralmost_empty_o,
               rd_cnt_o, rd_ack_o, underflow_o
    );
endinterface

// File: rtl/afifo_rd_ctrl.sv
// Async FIFO read-domain control: write-pointer synchronizer, read pointers,
// RAM read address, empty/almost-empty, fill count, ack and underflow.
module afifo_rd_ctrl #(
    parameter int PTR_WIDTH = 5,
    parameter int AEMPTY_TH = 2
) (
    input  logic            rd_clk_i,
    input  logic            rst_i,
    afifo_rd_ctrl_if.slave  rif
);
    localparam int PW = PTR_WIDTH + 1;
    localparam logic [PTR_WIDTH:0] AE_TH = PW'(AEMPTY_TH);

    logic [PTR_WIDTH:0] wp_syn1_q, wp_syn1_d;
    logic [PTR_WIDTH:0] wp_syn2_q, wp_syn2_d;
    logic [PTR_WIDTH:0] rbin_q, rbin_d;
    logic [PTR_WIDTH:0] rgray_q, rgray_d;
    logic [PTR_WIDTH:0] rd_cnt_q, rd_cnt_d;
    logic               rempty_q, rempty_d;
    logic               raempty_q, raempty_d;
    logic               rd_ack_q, rd_ack_d;
    logic               underflow_q, underflow_d;
    logic [PTR_WIDTH:0] wbin_s;
    logic               rd_fire;

    always_comb begin
        wp_syn1_d = rif.wptr_gray_i;
        wp_syn2_d = wp_syn1_q;

        wbin_s            = '0;
        wbin_s[PTR_WIDTH] = wp_syn2_q[PTR_WIDTH];
        for (int i = PTR_WIDTH - 1; i >= 0; i--)
            wbin_s[i] = wbin_s[i+1] ^ wp_syn2_q[i];

        rd_fire = rif.rd_en_i && !rempty_q;
        rbin_d  = rbin_q + {{PTR_WIDTH{1'b0}}, rd_fire};
        rgray_d = rbin_d ^ (rbin_d >> 1);

        // Flags look at the post-read pointer so the last entry empties on the
        // same edge that consumes it.
        rempty_d    = (rgray_d == wp_syn2_q);
        rd_cnt_d    = wbin_s - rbin_d;
        raempty_d   = (rd_cnt_d <= AE_TH);
        rd_ack_d    = rd_fire;
        underflow_d = rif.rd_en_i && rempty_q;
    end

    always_ff @(posedge rd_clk_i) begin
        if (rst_i) begin
            wp_syn1_q   <= '0;
            wp_syn2_q   <= '0;
            rbin_q      <= '0;
            rgray_q     <= '0;
            rd_cnt_q    <= '0;
            rempty_q    <= 1'b1;
            raempty_q   <= 1'b1;
            rd_ack_q    <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wp_syn1_q   <= wp_syn1_d;
            wp_syn2_q   <= wp_syn2_d;
            rbin_q      <= rbin_d;
            rgray_q     <= rgray_d;
            rd_cnt_q    <= rd_cnt_d;
            rempty_q    <= rempty_d;
            raempty_q   <= raempty_d;
            rd_ack_q    <= rd_ack_d;
            underflow_q <= underflow_d;
        end
    end

    assign rif.rptr_gray_o     = rgray_q;
    assign rif.raddr_o         = rbin_q[PTR_WIDTH-1:0];
    assign rif.rempty_o        = rempty_q;
    assign rif.ralmost_empty_o = raempty_q;
    assign rif.rd_cnt_o        = rd_cnt_q;
    assign rif.rd_ack_o        = rd_ack_q;
    assign rif.underflow_o     = underflow_q;
endmodule
